// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Widths here are the default 32-bit build; the top re-derives an entry type from its own parameters.
package ifu_prefetch_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         INST_BYTES  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO of fetched instructions; flush dominates push and pop.
// The head is read straight from the array so IDU sees it the cycle it lands.
module ifu_fetch_queue
  import ifu_prefetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW:0]   wr_ptr_reg;
  logic [PW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr_reg[PW-1:0]];
  assign count = CW'(wr_ptr_reg - rd_ptr_reg);
  // Equal index with differing wrap bits means the write side lapped the read side.
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/ifu_prefetch.sv
// Pipelined instruction prefetcher: in-order AR/R fetches, a prefetch queue towards IDU,
// and redirect handling that silently drops wrong-path responses still in flight.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_fault
);

  localparam int                    OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int                    QW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  fault;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] resp_pc_reg, resp_pc_next;
  logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  stale_ar_reg, stale_ar_next;
  logic [OW-1:0]         outstanding_reg, outstanding_next;
  logic [OW-1:0]         drop_cnt_reg, drop_cnt_next;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  drop_now;
  logic                  push;
  logic                  pop;
  logic                  can_issue;
  logic [QW-1:0]         q_count;
  logic [QW-1:0]         count_next;
  logic                  q_full;
  logic                  q_empty;
  entry_t                push_entry;
  entry_t                head;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  redirect_lsb_unused;

  assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Every accepted AR has a reserved queue slot, so responses never need back-pressure.
  assign rready = 1'b1;

  assign ar_hs    = arvalid_reg && arready;
  assign r_hs     = rvalid;
  assign drop_now = r_hs && (drop_cnt_reg != '0);
  assign push     = r_hs && !drop_now && !q_full;

  assign out_valid = !q_empty && !redirect_valid;
  assign pop       = out_valid && out_ready;

  assign push_entry = '{pc: resp_pc_reg, inst: rdata, fault: (rresp != RESP_OKAY)};

  // Credit is judged on the post-cycle occupancy so a retiring response frees its slot at once.
  assign count_next       = q_count + QW'(push) - QW'(pop);
  assign outstanding_next = outstanding_reg + OW'(ar_hs) - OW'(r_hs);
  assign can_issue = !redirect_valid && !stale_ar_reg &&
                     (int'(outstanding_next) < MAX_OUTSTANDING) &&
                     (int'(outstanding_next) + int'(count_next) < FIFO_DEPTH);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    araddr_next   = araddr_reg;
    arvalid_next  = arvalid_reg;
    stale_ar_next = stale_ar_reg;
    drop_cnt_next = drop_cnt_reg;

    if (ar_hs && !stale_ar_reg) fetch_pc_next = fetch_pc_reg + PC_STEP;
    if (push) resp_pc_next = resp_pc_reg + PC_STEP;
    if (drop_now) drop_cnt_next = drop_cnt_next - OW'(1);
    // A request that was stuck across a redirect is wrong-path once it finally goes out.
    if (ar_hs && stale_ar_reg) begin
      drop_cnt_next = drop_cnt_next + OW'(1);
      stale_ar_next = 1'b0;
    end

    if (!arvalid_reg || arready) begin
      arvalid_next = can_issue;
      if (can_issue) araddr_next = fetch_pc_next;
    end

    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
      resp_pc_next  = redirect_target;
      drop_cnt_next = outstanding_next;
      stale_ar_next = arvalid_reg && !arready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      araddr_reg      <= RESET_PC;
      arvalid_reg     <= 1'b0;
      stale_ar_reg    <= 1'b0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      araddr_reg      <= araddr_next;
      arvalid_reg     <= arvalid_next;
      stale_ar_reg    <= stale_ar_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  ifu_fetch_queue #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign araddr    = araddr_reg;
  assign arvalid   = arvalid_reg;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_fault = head.fault;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch: a reference instruction stream per path feeds a scoreboard,
// a queued memory model answers ARs in order, and a negedge monitor checks every handshake.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic          out_fault;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  exp_t  sb[$];
  mreq_t memq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ar_pct = 100, or_pct = 100, lat_min = 1, lat_max = 1;
  int ar_count = 0, out_count = 0, tb_out = 0, last_ready = 0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] exp_ar = RST_PC;
  logic [31:0] stale_addr = '0;
  logic [31:0] prev_araddr = '0;
  logic [31:0] redir_target = '0;
  bit stale_pending = 0, redir_req = 0, prev_hold = 0;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic bit mem_err(logic [31:0] a);
    return (a == 32'h8000_0008) || (a[31:28] == 4'h1 && a[4:2] == 3'd5);
  endfunction

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // One clock of stimulus: redirect request, random handshakes, in-order memory responses,
  // and top-up of the expected instruction stream for the current path.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (redir_req) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_req      = 0;
      sb.delete();
      model_pc = {redir_target[31:2], 2'b00};
    end
    arready   = ($urandom_range(99) < ar_pct);
    out_ready = ($urandom_range(99) < or_pct);
    if (!rst && memq.size() > 0 && memq[0].ready <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_data(memq[0].addr);
      rresp  = mem_err(memq[0].addr) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = RESP_OKAY;
    end
    while (sb.size() < 16) begin
      e.pc    = model_pc;
      e.inst  = mem_data(model_pc);
      e.fault = mem_err(model_pc);
      sb.push_back(e);
      model_pc += 32'd4;
    end
  endtask

  task automatic do_redirect(logic [31:0] target);
    redir_req    = 1;
    redir_target = target;
    step();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    memq.delete();
    sb.delete();
    model_pc  = RST_PC;
    redir_req = 0;
    repeat (n) step();
    check("reset_arvalid", arvalid, 0);
    check("reset_out_valid", out_valid, 0);
    rst = 1'b0;
  endtask

  // Monitor: everything observed here happens at the following rising edge.
  always @(negedge clk) begin
    exp_t  e;
    mreq_t m;
    int    lat;
    if (rst) begin
      exp_ar        = RST_PC;
      stale_pending = 0;
      tb_out        = 0;
      prev_hold     = 0;
      last_ready    = 0;
    end else begin
      if (prev_hold) begin
        check("ar_hold_valid", arvalid, 1);
        check("ar_hold_addr", araddr, prev_araddr);
      end
      if (redirect_valid) check("redirect_masks_out", out_valid, 0);
      if (rvalid) begin
        check("rready_on_rvalid", rready, 1);
        void'(memq.pop_front());
        tb_out--;
      end
      if (arvalid && arready) begin
        ar_count++;
        if (stale_pending) begin
          check("stale_ar_addr", araddr, stale_addr);
          stale_pending = 0;
        end else begin
          check("ar_addr", araddr, exp_ar);
          exp_ar += 32'd4;
        end
        lat = $urandom_range(lat_max, lat_min);
        m.addr  = araddr;
        m.ready = (cyc + lat < last_ready) ? last_ready : cyc + lat;
        last_ready = m.ready;
        memq.push_back(m);
        tb_out++;
        check("outstanding_le_max", (tb_out <= MAXO), 1);
      end
      if (redirect_valid) begin
        if (arvalid && !arready) begin
          stale_pending = 1;
          stale_addr    = araddr;
        end
        exp_ar = {redirect_pc[31:2], 2'b00};
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got pc %h, expected no instruction (cycle %0d)", out_pc, cyc);
        end else begin
          e = sb.pop_front();
          $display("[TB] out pc=%h inst=%h fault=%0d", out_pc, out_inst, out_fault);
          check("out_pc", out_pc, e.pc);
          check("out_inst", out_inst, e.inst);
          check("out_fault", out_fault, e.fault);
        end
      end
      prev_hold   = arvalid && !arready;
      prev_araddr = araddr;
    end
  end

  initial begin
    int k;
    logic [31:0] t;

    do_reset(3);

    // Fast memory, IDU always ready: stream from RESET_PC (0x80000008 returns an error).
    ar_pct = 100; or_pct = 100; lat_min = 1; lat_max = 1;
    repeat (10) step();
    out_count = 0;
    repeat (16) step();
    check("steady_rate", out_count, 16);

    // IDU stalled: a fresh path must fill exactly the queue and then stop requesting.
    or_pct = 0;
    do_redirect(32'h8000_0200);
    step();
    ar_count = 0;
    repeat (30) step();
    check("stall_ar_count", ar_count, DEPTH);
    check("stall_out_valid", out_valid, 1);
    or_pct = 100;
    repeat (20) step();

    // Three-cycle memory: redirect while two requests are in flight.
    lat_min = 3; lat_max = 3;
    repeat (20) step();
    k = 0;
    while (tb_out != 2 && k < 20) begin
      step();
      k++;
    end
    check("lat3_two_outstanding", tb_out, 2);
    do_redirect(32'h8000_0103);
    repeat (30) step();

    // Request stuck on arready=0 across a redirect.
    lat_min = 1; lat_max = 1; ar_pct = 0;
    k = 0;
    while (!arvalid && k < 20) begin
      step();
      k++;
    end
    check("stale_setup_arvalid", arvalid, 1);
    do_redirect(32'h8000_0400);
    repeat (5) step();
    ar_pct = 100;
    repeat (30) step();

    // Randomised traffic with redirects, wrap-around targets and one mid-run reset.
    for (int blk = 0; blk < 16; blk++) begin
      ar_pct  = $urandom_range(100, 30);
      or_pct  = $urandom_range(100, 20);
      lat_min = $urandom_range(3, 1);
      lat_max = lat_min + $urandom_range(3, 0);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(99) < 4) begin
          case ($urandom_range(3))
            0:       t = 32'hFFFF_FFF0 + 32'($urandom_range(15));
            1:       t = {4'h1, 28'($urandom)};
            default: t = $urandom;
          endcase
          do_redirect(t);
          if ($urandom_range(9) == 0) do_redirect($urandom);
        end else begin
          step();
        end
      end
      if (blk == 8) do_reset(2);
    end

    // Drain across the address wrap and confirm forward progress.
    ar_pct = 100; or_pct = 100; lat_min = 1; lat_max = 2;
    do_redirect(32'hFFFF_FFF8);
    out_count = 0;
    k = 0;
    while (out_count < 6 && k < 100) begin
      step();
      k++;
    end
    check("drain_progress", (out_count >= 6), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
